// File: rtl/ifetch_pc_unit_if.sv
// Fetch-stage bus between the Minisys-1A ID/control logic and ifetch_pc_unit.
// The master drives hazard/redirect controls and the ROM word; the slave owns PC and IF/ID.
`timescale 1ns/1ps
interface ifetch_pc_unit_if;
    logic        PCWrite;
    logic [31:0] IF_instruction;
    logic        IFBranch;
    logic        nBranch;
    logic        J;
    logic        JR;
    logic        IF_Flush;
    logic [31:0] rs;
    logic [31:0] PC;
    logic [31:0] ID_instruction;
    logic [31:0] ID_PC_plus_4;
    logic        ID_pred_taken;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    modport master (
        output PCWrite, IF_instruction, IFBranch, nBranch, J, JR, IF_Flush, rs,
        input  PC, ID_instruction, ID_PC_plus_4, ID_pred_taken, branch_count, mispredict_count
    );

    modport slave (
        input  PCWrite, IF_instruction, IFBranch, nBranch, J, JR, IF_Flush, rs,
        output PC, ID_instruction, ID_PC_plus_4, ID_pred_taken, branch_count, mispredict_count
    );
endinterface

// File: rtl/ifetch_pc_unit.sv
// Minisys-1A instruction fetch: PC register, IF/ID register, static predict-taken
// for IF-stage branches with fall-through recovery, and J/JR redirects from ID.
`timescale 1ns/1ps
module ifetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic             clock,
    input  logic             reset,
    ifetch_pc_unit_if.slave  bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] fallback_q, fallback_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        id_pred_q, id_pred_d;
    logic [15:0] branch_cnt_q, branch_cnt_d;
    logic [15:0] mispred_cnt_q, mispred_cnt_d;

    logic [31:0] pc4;
    logic [31:0] btarget;
    logic [31:0] jtarget;
    logic        predict_taken;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        pc_d          = pc_q;
        fallback_d    = fallback_q;
        id_instr_d    = id_instr_q;
        id_pc4_d      = id_pc4_q;
        id_pred_d     = id_pred_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        pc4     = pc_q + 32'd4;
        btarget = pc4 + {{14{bus.IF_instruction[15]}}, bus.IF_instruction[15:0], 2'b00};
        jtarget = {id_pc4_q[31:28], id_instr_q[25:0], 2'b00};

        // An IF branch only counts as a live prediction when no older ID redirect overrides it.
        predict_taken = bus.IFBranch && !bus.nBranch && !bus.J && !bus.JR;

        if (bus.PCWrite) begin
            if (bus.nBranch)       pc_d = fallback_q;
            else if (bus.JR)       pc_d = bus.rs;
            else if (bus.J)        pc_d = jtarget;
            else if (bus.IFBranch) pc_d = btarget;
            else                   pc_d = pc4;

            if (predict_taken) fallback_d = pc4;

            if (bus.IF_Flush) begin
                id_instr_d = NOP_WORD;
                id_pc4_d   = 32'd0;
                id_pred_d  = 1'b0;
            end else begin
                id_instr_d = bus.IF_instruction;
                id_pc4_d   = pc4;
                id_pred_d  = bus.IFBranch;
            end

            if (!bus.IF_Flush && bus.IFBranch && branch_cnt_q != 16'hFFFF)
                branch_cnt_d = branch_cnt_q + 16'd1;
            if (bus.nBranch && mispred_cnt_q != 16'hFFFF)
                mispred_cnt_d = mispred_cnt_q + 16'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            fallback_q    <= 32'd0;
            id_instr_q    <= NOP_WORD;
            id_pc4_q      <= 32'd0;
            id_pred_q     <= 1'b0;
            branch_cnt_q  <= 16'd0;
            mispred_cnt_q <= 16'd0;
        end else begin
            pc_q          <= pc_d;
            fallback_q    <= fallback_d;
            id_instr_q    <= id_instr_d;
            id_pc4_q      <= id_pc4_d;
            id_pred_q     <= id_pred_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bus.PC               = pc_q;
    assign bus.ID_instruction   = id_instr_q;
    assign bus.ID_PC_plus_4     = id_pc4_q;
    assign bus.ID_pred_taken    = id_pred_q;
    assign bus.branch_count     = branch_cnt_q;
    assign bus.mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_ifetch_pc_unit.sv
// Directed bench for ifetch_pc_unit: a sequential vector table from reset plus
// hand-written stall, saturation and reset-during-redirect sequences.
`timescale 1ns/1ps
module tb_ifetch_pc_unit;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    ifetch_pc_unit_if bus ();

    ifetch_pc_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        pcw;
        logic [31:0] instr;
        logic        ifb;
        logic        nb;
        logic        j;
        logic        jr;
        logic        fl;
        logic [31:0] rs;
        logic [31:0] e_pc;
        logic [31:0] e_id;
        logic [31:0] e_pc4;
        logic        e_pred;
        logic [15:0] e_b;
        logic [15:0] e_m;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic pcw, input logic [31:0] instr,
                                input logic ifb, input logic nb, input logic j,
                                input logic jr, input logic fl, input logic [31:0] rs,
                                input logic [31:0] e_pc, input logic [31:0] e_id,
                                input logic [31:0] e_pc4, input logic e_pred,
                                input logic [15:0] e_b, input logic [15:0] e_m);
        vec_t v;
        v.pcw = pcw; v.instr = instr; v.ifb = ifb; v.nb = nb; v.j = j; v.jr = jr;
        v.fl = fl; v.rs = rs; v.e_pc = e_pc; v.e_id = e_id; v.e_pc4 = e_pc4;
        v.e_pred = e_pred; v.e_b = e_b; v.e_m = e_m;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.PCWrite        = v.pcw;
        bus.IF_instruction = v.instr;
        bus.IFBranch       = v.ifb;
        bus.nBranch        = v.nb;
        bus.J              = v.j;
        bus.JR             = v.jr;
        bus.IF_Flush       = v.fl;
        bus.rs             = v.rs;
    endtask

    task automatic compare(input string tag, input vec_t v);
        check({tag, ".PC"},            bus.PC,                       v.e_pc);
        check({tag, ".ID_instr"},      bus.ID_instruction,           v.e_id);
        check({tag, ".ID_PC_plus_4"},  bus.ID_PC_plus_4,             v.e_pc4);
        check({tag, ".ID_pred_taken"}, {31'd0, bus.ID_pred_taken},   {31'd0, v.e_pred});
        check({tag, ".branch_count"},  {16'd0, bus.branch_count},    {16'd0, v.e_b});
        check({tag, ".mispred_count"}, {16'd0, bus.mispredict_count},{16'd0, v.e_m});
    endtask

    // Apply one vector for one clock and compare outputs #1 after the edge.
    task automatic run_vec(input string tag, input vec_t v);
        drive(v);
        @(posedge clock);
        #1;
        compare(tag, v);
    endtask

    initial begin
        vec_t v;
        n_checks = 0;
        n_errors = 0;

        // Sequential table from reset; comments give the PC the vector is applied at.
        vecs.push_back(mk(1, 32'h2001_0005, 0,0,0,0,0, 32'h0, 32'h0000_0004, 32'h2001_0005, 32'h0000_0004, 0, 0, 0)); // 0x0
        vecs.push_back(mk(1, 32'h2001_0005, 0,0,0,0,0, 32'h0, 32'h0000_0008, 32'h2001_0005, 32'h0000_0008, 0, 0, 0));
        vecs.push_back(mk(1, 32'h2001_0005, 0,0,0,0,0, 32'h0, 32'h0000_000C, 32'h2001_0005, 32'h0000_000C, 0, 0, 0));
        vecs.push_back(mk(1, 32'h2001_0005, 0,0,0,0,0, 32'h0, 32'h0000_0010, 32'h2001_0005, 32'h0000_0010, 0, 0, 0));
        vecs.push_back(mk(1, 32'h1085_0004, 1,0,0,0,0, 32'h0, 32'h0000_0024, 32'h1085_0004, 32'h0000_0014, 1, 1, 0)); // 0x10 predict
        vecs.push_back(mk(1, 32'h2001_0005, 0,1,0,0,1, 32'h0, 32'h0000_0014, 32'h0000_0000, 32'h0000_0000, 0, 1, 1)); // mispredict
        vecs.push_back(mk(1, 32'h0000_0000, 0,0,0,0,0, 32'h0, 32'h0000_0018, 32'h0000_0000, 32'h0000_0018, 0, 1, 1));
        vecs.push_back(mk(1, 32'h0000_0000, 0,0,0,0,0, 32'h0, 32'h0000_001C, 32'h0000_0000, 32'h0000_001C, 0, 1, 1));
        vecs.push_back(mk(1, 32'h0000_0000, 0,0,0,0,0, 32'h0, 32'h0000_0020, 32'h0000_0000, 32'h0000_0020, 0, 1, 1));
        vecs.push_back(mk(1, 32'h1000_FFFF, 1,0,0,0,0, 32'h0, 32'h0000_0020, 32'h1000_FFFF, 32'h0000_0024, 1, 2, 1)); // self-loop
        vecs.push_back(mk(1, 32'h0000_0000, 0,0,0,1,1, 32'h0000_0400, 32'h0000_0400, 32'h0, 32'h0, 0, 2, 1));         // JR
        vecs.push_back(mk(1, 32'h0000_0000, 0,0,0,0,0, 32'h0, 32'h0000_0404, 32'h0000_0000, 32'h0000_0404, 0, 2, 1));
        vecs.push_back(mk(1, 32'h0000_0000, 0,0,0,1,1, 32'h1000_0004, 32'h1000_0004, 32'h0, 32'h0, 0, 2, 1));
        vecs.push_back(mk(1, 32'h0800_0040, 0,0,0,0,0, 32'h0, 32'h1000_0008, 32'h0800_0040, 32'h1000_0008, 0, 2, 1));
        vecs.push_back(mk(1, 32'h0000_0000, 0,0,1,0,1, 32'h0, 32'h1000_0100, 32'h0, 32'h0, 0, 2, 1));                 // J
        vecs.push_back(mk(1, 32'h0000_0000, 0,0,0,1,1, 32'h0, 32'h0000_0000, 32'h0, 32'h0, 0, 2, 1));                 // JR to 0
        vecs.push_back(mk(1, 32'h1000_FFFE, 1,0,0,0,0, 32'h0, 32'hFFFF_FFFC, 32'h1000_FFFE, 32'h0000_0004, 1, 3, 1)); // wrap
        vecs.push_back(mk(1, 32'h0000_0000, 0,0,0,1,1, 32'h0000_0203, 32'h0000_0203, 32'h0, 32'h0, 0, 3, 1));         // unaligned rs
        vecs.push_back(mk(1, 32'h1000_0010, 1,1,0,1,1, 32'h0000_0500, 32'h0000_0004, 32'h0, 32'h0, 0, 3, 2));         // nBranch wins
        vecs.push_back(mk(1, 32'h0000_0000, 0,1,0,0,1, 32'h0, 32'h0000_0004, 32'h0, 32'h0, 0, 3, 3));                 // fallback kept
        vecs.push_back(mk(1, 32'h0800_0040, 0,0,0,0,0, 32'h0, 32'h0000_0008, 32'h0800_0040, 32'h0000_0008, 0, 3, 3));

        // Reset for two cycles with a live instruction on the bus.
        v = mk(1, 32'h2001_0005, 0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        drive(v);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        compare("reset", v);
        reset = 1'b0;

        foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Stall: J and a counted IF branch are presented but everything must hold.
        for (int i = 0; i < 3; i++)
            run_vec($sformatf("stall%0d", i),
                    mk(0, 32'h1000_0010, 1,0,1,0,0, 32'h0, 32'h0000_0008, 32'h0800_0040, 32'h0000_0008, 0, 3, 3));
        run_vec("stall_release_j",
                mk(1, 32'h1000_0010, 1,0,1,0,1, 32'h0, 32'h0000_0100, 32'h0, 32'h0, 0, 3, 3));
        run_vec("after_j_once",
                mk(1, 32'h0000_0000, 0,0,0,0,0, 32'h0, 32'h0000_0104, 32'h0, 32'h0000_0104, 0, 3, 3));
        run_vec("fallback_after_stall",
                mk(1, 32'h0000_0000, 0,1,0,0,1, 32'h0, 32'h0000_0004, 32'h0, 32'h0, 0, 3, 4));

        // Drive mispredict_count from 4 up to saturation.
        drive(mk(1, 32'h0, 0,1,0,0,1, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0));
        repeat (65531) @(posedge clock);
        #1;
        check("mispred_at_max", {16'd0, bus.mispredict_count}, 32'h0000_FFFF);
        run_vec("mispred_saturated",
                mk(1, 32'h0000_0000, 0,1,0,0,1, 32'h0, 32'h0000_0004, 32'h0, 32'h0, 0, 3, 16'hFFFF));

        // Reset during a mispredict recovery discards the saved fallback.
        v = mk(1, 32'h0000_0000, 0,1,0,0,1, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        drive(v);
        reset = 1'b1;
        @(posedge clock);
        #1;
        compare("reset_mid_redirect", v);
        reset = 1'b0;
        run_vec("recover_after_reset",
                mk(1, 32'h0000_0000, 0,1,0,0,1, 32'h0, 32'h0000_0000, 32'h0, 32'h0, 0, 0, 1));
        run_vec("run_after_reset",
                mk(1, 32'h0000_0000, 0,0,0,0,0, 32'h0, 32'h0000_0004, 32'h0, 32'h0000_0004, 0, 0, 1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ifetch_pc_unit.md
Name: ifetch_pc_unit

Overview:
Instruction-fetch stage of the Minisys-1A pipeline. It owns the PC register, the IF/ID pipeline register, and static predict-taken handling for conditional branches. Backward-taken and forward-taken are treated alike: every IF-stage branch redirects immediately to its target. When the ID-stage branch test reports a misprediction, the unit recovers to the saved fall-through PC. It also applies J/JR redirects from ID and flushes the wrong-path instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_WORD, 32'h0000_0000, word injected into IF/ID on flush

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
PCWrite  in  1  0 = hazard stall: PC, fallback, IF/ID, counters all hold
IF_instruction  in  32  instruction word fetched at PC (combinational ROM read)
IFBranch  in  1  current IF_instruction is a conditional branch (opcode decode from ID-stage branch unit)
nBranch  in  1  ID branch was predicted taken but is not taken (already gated with PCWrite)
J  in  1  ID instruction is j/jal
JR  in  1  ID instruction is jr/jalr
IF_Flush  in  1  squash the instruction currently in IF
rs  in  32  forwarded register[rs] from ID (JR target)
PC  out  32  current fetch address
ID_instruction  out  32  IF/ID instruction register
ID_PC_plus_4  out  32  IF/ID copy of fetch PC+4
ID_pred_taken  out  1  ID instruction was redirected as predicted-taken
branch_count  out  16  predicted branches entering ID, saturating
mispredict_count  out  16  nBranch events, saturating

Behaviour:
- Reset (synchronous, dominates everything): PC=RESET_PC; ID_instruction=NOP_WORD; ID_PC_plus_4=0; ID_pred_taken=0; fallback=0; both counters=0.
- Combinational: pc4 = PC+4 (mod 2^32). btarget = pc4 + ({{14{IF_instruction[15]}},IF_instruction[15:0],2'b00}), 32-bit wrap. jtarget = {ID_PC_plus_4[31:28], ID_instruction[25:0], 2'b00}.
- Next-PC priority when PCWrite=1:
  1. nBranch: fallback
  2. JR: rs
  3. J: jtarget
  4. IFBranch: btarget
  5. otherwise: pc4
- Fallback register: loaded with pc4 only when PCWrite=1, IFBranch=1, and none of nBranch/J/JR is asserted (i.e. the prediction is actually taken). Otherwise it holds. Back-to-back branches (correct ID branch plus new IF branch) overwrite the register in the same cycle; the ID branch is resolved that cycle, so this is correct.
- IF/ID register when PCWrite=1:
  - IF_Flush=1: ID_instruction=NOP_WORD, ID_PC_plus_4=0, ID_pred_taken=0.
  - IF_Flush=0: ID_instruction=IF_instruction, ID_PC_plus_4=pc4, ID_pred_taken=IFBranch.
- PCWrite=0: all registers hold. J/JR/nBranch are ignored and are re-presented next cycle because ID holds.
- Latency: redirect takes effect on PC at the next edge. Exactly one wrong-path slot is flushed per redirect.
- Counters (PCWrite=1 only):
  - branch_count increments when IF_Flush=0 and IFBranch=1.
  - mispredict_count increments on nBranch.
  - Both saturate at 16'hFFFF; no wrap.
- No alignment check: PC[1:0] from rs is passed through unchanged.
- Reset mid-redirect: reset wins, and any pending fallback is discarded.

Test Plan:
1. Reset: assert reset 2 cycles with IF_instruction=32'h2001_0005 → PC=0, ID_instruction=0, ID_pred_taken=0, counters=0. Release with no branches → PC sequence 0x0, 0x4, 0x8, 0xC; ID_PC_plus_4 lags PC+4 by one cycle.
2. Predict taken, then mispredict:
   - PC=0x10, IF_instruction=32'h1085_0004, IFBranch=1 → next PC=0x24, ID_pred_taken=1, branch_count=1.
   - Next cycle, nBranch=1 and IF_Flush=1 → PC=0x14, ID_instruction=0, mispredict_count=1.
3. Negative offset: PC=0x20, offset 16'hFFFF, IFBranch=1 → PC=0x20. At PC=0x0 with offset 16'hFFFE → PC=0xFFFF_FFFC (wrap).
4. Jumps:
   - JR=1, rs=0x0000_0400, IF_Flush=1 → PC=0x400, ID_instruction=NOP.
   - J=1 with ID_instruction=32'h0800_0040, ID_PC_plus_4=0x1000_0008 → PC=0x1000_0100.
5. Stall: PCWrite=0 for 3 cycles with J=1 and IFBranch=1 → PC, IF/ID, fallback, counters unchanged. PCWrite returns to 1 → J redirect applied exactly once.
6. Priority and saturation:
   - nBranch=1, JR=1, IFBranch=1 together → PC=fallback, and fallback is not reloaded.
   - Preload mispredict_count to 16'hFFFF via 65535 events, apply one more nBranch → count stays 16'hFFFF.
